// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
//
// Command engine that sits behind a UART's RX/TX FIFOs and lets a remote host
// peek and poke an on-chip register bus. Frames:
//   write : CMD_WR, addr, data  -> register write, reply RSP_ACK
//   read  : CMD_RD, addr        -> register read,  reply with read data
//   other opcode                -> reply RSP_NAK, bump err_cnt
// Exactly one reply byte is pushed per frame. Frames are handled strictly in
// order.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   rx_empty, r_data    RX FIFO status and head byte
//   rd_uart             RX FIFO pop strobe (combinational)
//   tx_full             TX FIFO full
//   wr_uart, w_data     TX FIFO push strobe and byte
//   reg_addr, reg_wdata register bus address / write data (registered, held)
//   reg_we, reg_re      one-cycle register write / read strobes
//   reg_rdata           register read data, valid the cycle after reg_re
//   busy                high whenever the engine is not idle
//   err_cnt             saturating count of NAK replies
//
// Optional build macro UART_BRIDGE_TIMEOUT_EN:
//   When defined, a frame that stalls for TIMEOUT_CYC cycles waiting for its
//   address or data byte is abandoned with a NAK reply. When undefined, the
//   engine waits indefinitely for the rest of a frame.
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] CMD_WR      = 8'h57,
  parameter logic [7:0] CMD_RD      = 8'h52,
  parameter logic [7:0] RSP_ACK     = 8'h4B,
  parameter logic [7:0] RSP_NAK     = 8'h3F,
  parameter int         TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_WAIT, SEND
  } state_t;

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;     // 1 = write frame, 0 = read frame
  logic [7:0]        w_data_q, w_data_d;   // reply byte, loaded on entry to SEND
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              busy_q, busy_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int             TMO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = rx_empty && (tmo_q == TMO_MAX);
`endif

  // Pops are only allowed in byte-collecting states; gating with reset keeps
  // the FIFO untouched while the engine is held in reset.
  assign rd_uart = !reset && !rx_empty &&
                   (state_q inside {IDLE, GET_ADDR, GET_DATA});

  // Push in the SEND cycle itself so a write replies two cycles after its
  // last byte; w_data is already registered and stable by then.
  assign wr_uart = (state_q == SEND) && !tx_full;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    w_data_d    = w_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (rd_uart) begin
          if (r_data == CMD_WR) begin
            op_wr_d = 1'b1;
            state_d = GET_ADDR;
          end else if (r_data == CMD_RD) begin
            op_wr_d = 1'b0;
            state_d = GET_ADDR;
          end else begin
            w_data_d  = RSP_NAK;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            state_d   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rd_uart) begin
          reg_addr_d = r_data[ADDR_W-1:0];
          state_d    = op_wr_q ? GET_DATA : REG_RD;
        end
`ifdef UART_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          w_data_d  = RSP_NAK;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = SEND;
        end
`endif
      end
      GET_DATA: begin
        if (rd_uart) begin
          reg_wdata_d = r_data;
          state_d     = REG_WR;
        end
`ifdef UART_BRIDGE_TIMEOUT_EN
        else if (tmo_hit) begin
          w_data_d  = RSP_NAK;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          state_d   = SEND;
        end
`endif
      end
      REG_WR: begin
        w_data_d = RSP_ACK;
        state_d  = SEND;
      end
      REG_RD: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        w_data_d = reg_rdata;
        state_d  = SEND;
      end
      SEND: begin
        if (!tx_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes and busy are decoded from the next state so they are flops
    // that are high exactly for the cycles spent in the matching state.
    reg_we_d = (state_d == REG_WR);
    reg_re_d = (state_d == REG_RD);
    busy_d   = (state_d != IDLE);

`ifdef UART_BRIDGE_TIMEOUT_EN
    // Count only while parked in a byte-collecting state; any transition
    // (pop, timeout, or entry) restarts from zero.
    if ((state_d == state_q) && (state_q inside {GET_ADDR, GET_DATA}) && rx_empty)
      tmo_d = tmo_q + 1'b1;
    else
      tmo_d = '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_wr_q     <= 1'b0;
      w_data_q    <= 8'h00;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= 8'h00;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      w_data_q    <= w_data_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign w_data    = w_data_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bridge
//
// Directed bench for uart_reg_bridge. An RX FIFO model feeds command bytes, a
// register array answers reads and absorbs writes, and a scoreboard holds the
// expected TX bytes and register strobes. A monitor process pops and compares
// whenever the DUT pushes a TX byte or pulses a register strobe.
// -----------------------------------------------------------------------------
module tb_uart_reg_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic       rd_uart, wr_uart, reg_we, reg_re, busy;
  logic [7:0] w_data, reg_addr, reg_wdata, reg_rdata, err_cnt;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT_CYC(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_empty  (rx_empty),
    .r_data    (r_data),
    .rd_uart   (rd_uart),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rx_q[$];     // RX FIFO model contents
  logic [7:0]  exp_tx[$];   // expected TX bytes
  logic [15:0] exp_we[$];   // expected {addr, data} per reg_we pulse
  logic [7:0]  exp_re[$];   // expected addr per reg_re pulse
  logic [7:0]  mem [0:255]; // register model
  int          rx_pushed = 0;
  int          rx_popped = 0;
  int          tx_count  = 0;
  logic        pop_pending = 1'b0;

  assign reg_rdata = mem[reg_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h, required no event", name, act);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_q.push_back(b);
    rx_pushed++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // RX FIFO model: the DUT consumes at a posedge when rd_uart is high, so the
  // pop decision is sampled mid-cycle and applied at the following negedge.
  always @(negedge clk) begin
    logic [7:0] dropped;
    if (pop_pending && rx_q.size() != 0) begin
      dropped = rx_q.pop_front();
      rx_popped++;
    end
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
    #1 pop_pending = rd_uart;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    #1;
    if (wr_uart) begin
      tx_count++;
      if (exp_tx.size() == 0) unexpected("tx_unexpected", {24'h0, w_data});
      else                    check("tx_byte", {24'h0, w_data}, {24'h0, exp_tx.pop_front()});
    end
    if (reg_we) begin
      mem[reg_addr] = reg_wdata;
      if (exp_we.size() == 0) unexpected("we_unexpected", {16'h0, reg_addr, reg_wdata});
      else                    check("we_addr_data", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_we.pop_front()});
    end
    if (reg_re) begin
      if (exp_re.size() == 0) unexpected("re_unexpected", {24'h0, reg_addr});
      else                    check("re_addr", {24'h0, reg_addr}, {24'h0, exp_re.pop_front()});
    end
  end

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_we.size() != 0 ||
            exp_re.size() != 0 || busy || pop_pending) && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'h0, (n < max)}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_uart"},   {31'h0, wr_uart},   32'h0);
    check({tag, "_rd_uart"},   {31'h0, rd_uart},   32'h0);
    check({tag, "_reg_we"},    {31'h0, reg_we},    32'h0);
    check({tag, "_reg_re"},    {31'h0, reg_re},    32'h0);
    check({tag, "_busy"},      {31'h0, busy},      32'h0);
    check({tag, "_w_data"},    {24'h0, w_data},    32'h0);
    check({tag, "_reg_addr"},  {24'h0, reg_addr},  32'h0);
    check({tag, "_reg_wdata"}, {24'h0, reg_wdata}, 32'h0);
    check({tag, "_err_cnt"},   {24'h0, err_cnt},   32'h0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    cyc(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    cyc(2);

    // 1: write 57,10,A5 -> reg_we {10,A5}, reply 4B
    exp_we.push_back({8'h10, 8'hA5});
    exp_tx.push_back(8'h4B);
    rx_push(8'h57); rx_push(8'h10); rx_push(8'hA5);
    wait_drain("t1_drain", 40);
    check("t1_err_cnt", {24'h0, err_cnt}, 32'h0);

    // 2: read 52,10 with register holding 3C -> reg_re 10, reply 3C
    mem[8'h10] = 8'h3C;
    exp_re.push_back(8'h10);
    exp_tx.push_back(8'h3C);
    rx_push(8'h52); rx_push(8'h10);
    wait_drain("t2_drain", 40);

    // 3: bad opcode then write -> 3F, 4B; err_cnt 1
    exp_tx.push_back(8'h3F);
    exp_tx.push_back(8'h4B);
    exp_we.push_back({8'h01, 8'h02});
    rx_push(8'h00); rx_push(8'h57); rx_push(8'h01); rx_push(8'h02);
    wait_drain("t3_drain", 60);
    check("t3_err_cnt",   {24'h0, err_cnt},   32'h1);
    check("t3_reg_wdata", {24'h0, reg_wdata}, 32'h02);

    // 4: TX backpressure during a read reply, next frame already queued
    mem[8'h33] = 8'h77;
    tx_full = 1'b1;
    exp_re.push_back(8'h33);
    exp_tx.push_back(8'h77);
    exp_tx.push_back(8'h4B);
    exp_we.push_back({8'h44, 8'h55});
    rx_push(8'h52); rx_push(8'h33); rx_push(8'h57); rx_push(8'h44); rx_push(8'h55);
    cyc(10);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (wr_uart || rd_uart || w_data !== 8'h77) bad++;
    end
    check("t4_hold_violations", bad, 0);
    check("t4_rx_untouched",    rx_q.size(), 3);
    check("t4_busy",            {31'h0, busy}, 32'h1);
    @(negedge clk);
    tx_full = 1'b0;
    wait_drain("t4_drain", 60);

    // 5a: gaps between frame bytes
    exp_we.push_back({8'h20, 8'hFF});
    exp_tx.push_back(8'h4B);
    rx_push(8'h57);
    cyc(50);
    check("t5_busy_gap1", {31'h0, busy}, 32'h1);
    rx_push(8'h20);
    cyc(50);
    check("t5_busy_gap2", {31'h0, busy}, 32'h1);
    rx_push(8'hFF);
    wait_drain("t5_drain", 40);

    // 5b: reset after the address byte discards the frame
    rx_push(8'h57); rx_push(8'h20);
    cyc(6);
    check("t5_busy_midframe", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    cyc(2);
    check_reset_outputs("midrst");
    reset = 1'b0;
    cyc(2);
    mem[8'h05] = 8'hC3;
    exp_re.push_back(8'h05);
    exp_tx.push_back(8'hC3);
    rx_push(8'h52); rx_push(8'h05);
    wait_drain("t5_after_reset", 40);

    // 6: lone opcode
`ifdef UART_BRIDGE_TIMEOUT_EN
    exp_tx.push_back(8'h3F);
    rx_push(8'h57);
    wait_drain("t6_timeout_nak", 200);
    check("t6_err_cnt", {24'h0, err_cnt}, 32'h1);
`else
    begin
      int tx_before;
      tx_before = tx_count;
      rx_push(8'h57);
      cyc(1000);
      check("t6_no_reply", tx_count, tx_before);
      check("t6_busy",     {31'h0, busy}, 32'h1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(2);
    end
`endif

    check("pops_equal_pushes", rx_popped, rx_pushed);
    check("scoreboard_empty", exp_tx.size() + exp_we.size() + exp_re.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
